// File: rtl/ide_mgmt_arbiter.sv
// ide_mgmt_arbiter
// Shares one MCU management port between two IDE channel cores. Each channel
// raises a 3-bit request code. One channel at a time is granted the MCU,
// in round-robin order. While a channel is owned, the MCU strobes and the
// readback are routed to that channel only. Ownership ends on a write to
// address 5 (command completion) or when the inactivity watchdog expires.
//
// Ports
//   clk, reset                  clock, asynchronous active-high reset
//   ch_request0/1               request codes from channel 0/1 (000 = none)
//   ch_mgmt_address/writedata   MCU address/data copied to both channels
//   ch_mgmt_write/read          per-channel strobes, bit n = channel n
//   ch_mgmt_readdata0/1         readback from channel 0/1
//   mcu_address/write/writedata/read  MCU management access
//   mcu_readdata                readback from the granted channel (FFFF if none)
//   mcu_cfg_sel                 channel mask for address-6 config writes
//   mcu_clr_to                  clears the sticky timeout flag
//   mcu_irq                     high while a channel is granted
//   mcu_status                  {own, to_flag, 2'b00, gnt_ch, req_code}
module ide_mgmt_arbiter #(
  parameter int unsigned          TO_W     = 16,
  parameter logic [TO_W-1:0]      TO_LIMIT = 16'hFFFF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  ch_request0,
  input  logic [2:0]  ch_request1,
  output logic [3:0]  ch_mgmt_address,
  output logic [15:0] ch_mgmt_writedata,
  output logic [1:0]  ch_mgmt_write,
  output logic [1:0]  ch_mgmt_read,
  input  logic [15:0] ch_mgmt_readdata0,
  input  logic [15:0] ch_mgmt_readdata1,
  input  logic [3:0]  mcu_address,
  input  logic        mcu_write,
  input  logic [15:0] mcu_writedata,
  input  logic        mcu_read,
  output logic [15:0] mcu_readdata,
  input  logic [1:0]  mcu_cfg_sel,
  input  logic        mcu_clr_to,
  output logic        mcu_irq,
  output logic [7:0]  mcu_status
);

  typedef enum logic [1:0] {IDLE, OWN, WAIT_FALL, GAP} state_t;

  state_t          state, state_nxt;
  logic            last, last_nxt;
  logic            gnt_ch, gnt_nxt;
  logic [2:0]      req_code, req_nxt;
  logic            to_flag;
  logic [TO_W-1:0] wd;
  logic            gap_cnt;
  logic [1:0]      pend;
  logic            owned;
  logic            access;
  logic            wd_fire;
  logic            cfg_wr;

  assign pend    = {|ch_request1, |ch_request0};
  assign owned   = (state == OWN) || (state == WAIT_FALL);
  assign access  = mcu_read | mcu_write;
  // An active strobe always resets the watchdog, so it can never fire mid-access.
  assign wd_fire = (state == OWN) && !access && (wd == TO_LIMIT);
  assign cfg_wr  = mcu_write && (mcu_address == 4'd6);

  assign ch_mgmt_address   = mcu_address;
  assign ch_mgmt_writedata = mcu_writedata;
  assign mcu_irq           = owned;

  always_comb begin
    state_nxt = state;
    last_nxt  = last;
    gnt_nxt   = gnt_ch;
    req_nxt   = req_code;
    case (state)
      IDLE: begin
        if (|pend) begin
          state_nxt = OWN;
          // On a tie the channel that was not served last wins.
          gnt_nxt   = (&pend) ? ~last : pend[1];
          req_nxt   = gnt_nxt ? ch_request1 : ch_request0;
        end
      end
      OWN: begin
        if (mcu_write && (mcu_address == 4'd5)) begin
          state_nxt = WAIT_FALL;
        end else if (wd_fire) begin
          state_nxt = GAP;
          last_nxt  = gnt_ch;
        end
      end
      WAIT_FALL: begin
        // Hold the route until the completion strobe has fully fallen.
        if (!mcu_write) begin
          state_nxt = GAP;
          last_nxt  = gnt_ch;
        end
      end
      GAP: begin
        if (gap_cnt) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    ch_mgmt_write = 2'b00;
    ch_mgmt_read  = 2'b00;
    mcu_readdata  = 16'hFFFF;
    if (owned) begin
      ch_mgmt_write[gnt_ch] = mcu_write;
      ch_mgmt_read[gnt_ch]  = mcu_read;
      mcu_readdata          = gnt_ch ? ch_mgmt_readdata1 : ch_mgmt_readdata0;
    end
    // Config writes reach the selected channels regardless of ownership.
    if (cfg_wr) ch_mgmt_write = mcu_cfg_sel;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      last       <= 1'b1;
      gnt_ch     <= 1'b0;
      req_code   <= 3'b000;
      to_flag    <= 1'b0;
      wd         <= '0;
      gap_cnt    <= 1'b0;
      mcu_status <= 8'h00;
    end else begin
      state    <= state_nxt;
      last     <= last_nxt;
      gnt_ch   <= gnt_nxt;
      req_code <= req_nxt;
      gap_cnt  <= (state == GAP) ? ~gap_cnt : 1'b0;
      // Outside OWN the counter is held at 0, so every new grant starts fresh.
      if ((state == OWN) && !access) wd <= wd + 1'b1;
      else                           wd <= '0;
      if (wd_fire)         to_flag <= 1'b1;
      else if (mcu_clr_to) to_flag <= 1'b0;
      mcu_status <= {owned, to_flag, 2'b00, gnt_ch, req_code};
    end
  end

endmodule
